// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg : shared types and segment table for the display scheduler
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  typedef enum logic [0:0] {
    LIVE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } disp_ev_t;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first down to entry 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/disp_sched_if.sv
// ============================================================================
// disp_sched_if : CPU/board-side bundle for the display scheduler
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface disp_sched_if;

  logic        ev_valid;
  logic [7:0]  ev_addr;
  logic [15:0] ev_data;
  logic        show;
  logic [31:0] rdata;
  logic [7:0]  pclow;
  logic [4:0]  state;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        busy;
  logic        ev_drop;

  modport master (
    output ev_valid, ev_addr, ev_data, show, rdata, pclow, state,
    input  seg, an, busy, ev_drop
  );

  modport slave (
    input  ev_valid, ev_addr, ev_data, show, rdata, pclow, state,
    output seg, an, busy, ev_drop
  );

endinterface

`default_nettype wire

// File: rtl/disp_sched_seg7_hex.sv
// ============================================================================
// seg7_hex : combinational hex nibble to active-low seven-segment decoder
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module seg7_hex
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

`default_nettype wire

// File: rtl/disp_sched.sv
// ============================================================================
// disp_sched : 8-digit display scheduler, live CPU view pre-empted by
//              memory-write events held for HOLD_FRAMES scan frames.
//              Optional: DISP_BLANK_EN blanks leading zeros in the live view.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module disp_sched
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 262144,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic           clk,
  input  logic           reset,
  disp_sched_if.slave    bus
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [0:0] S_LIVE = LIVE;
  localparam logic [0:0] S_HOLD = HOLD;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        dig_q, dig_d;
  logic [6:0]        seg_q, seg_d;
  logic [7:0]        an_q, an_d;
  logic [0:0]        fsm_q, fsm_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  disp_ev_t          cur_q, cur_d;
  disp_ev_t          pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic              drop_q, drop_d;

  logic              tick;
  logic              frame_end;
  logic              expiry;
  logic [31:0]       word;
  logic [3:0]        nib;
  logic [6:0]        hex_seg;
  logic              blank;
  disp_ev_t          ev_in;

  assign tick      = (pre_q == PRE_LAST);
  assign frame_end = tick && (dig_q == 3'd7);
  assign expiry    = frame_end && (hold_q == HOLD_ONE);
  assign ev_in     = '{addr: bus.ev_addr, data: bus.ev_data};

  always_comb begin
    word = 32'h0;
    if (fsm_q == S_HOLD) begin
      word = {8'hEE, cur_q.addr, cur_q.data};
    end else if (bus.show) begin
      word = bus.rdata;
    end else begin
      word = {16'h0, bus.pclow, 3'b000, bus.state};
    end
  end

  assign nib = word[{dig_q, 2'b00} +: 4];

  seg7_hex u_hex (
    .nib (nib),
    .seg (hex_seg)
  );

`ifdef DISP_BLANK_EN
  // Blank when this digit and everything above it is zero; digit 0 always shows.
  assign blank = (fsm_q == S_LIVE) && (dig_q != 3'd0) &&
                 ((word >> {dig_q, 2'b00}) == 32'h0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    dig_d = dig_q;
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      dig_d = dig_q + 3'd1;
      an_d  = blank ? 8'hFF : ~(8'h01 << dig_q);
      seg_d = blank ? SEG_BLANK : hex_seg;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    hold_d   = hold_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    drop_d   = 1'b0;
    if (fsm_q == S_LIVE) begin
      if (bus.ev_valid) begin
        cur_d  = ev_in;
        hold_d = HOLD_INIT;
        fsm_d  = S_HOLD;
      end
    end else if (expiry) begin
      // An event arriving on the expiry edge is never dropped: it either
      // becomes current or refills the slot just vacated by the pending one.
      hold_d   = HOLD_INIT;
      pend_v_d = 1'b0;
      if (pend_v_q) begin
        cur_d = pend_q;
        if (bus.ev_valid) begin
          pend_d   = ev_in;
          pend_v_d = 1'b1;
        end
      end else if (bus.ev_valid) begin
        cur_d = ev_in;
      end else begin
        fsm_d = S_LIVE;
      end
    end else begin
      if (frame_end) begin
        hold_d = hold_q - HOLD_ONE;
      end
      if (bus.ev_valid) begin
        pend_d   = ev_in;
        pend_v_d = 1'b1;
        drop_d   = pend_v_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      dig_q    <= 3'd0;
      seg_q    <= SEG_BLANK;
      an_q     <= 8'hFF;
      fsm_q    <= S_LIVE;
      hold_q   <= '0;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fsm_q    <= fsm_d;
      hold_q   <= hold_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.busy    = (fsm_q == S_HOLD);
  assign bus.ev_drop = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_sched.sv
// ============================================================================
// tb_disp_sched : directed self-checking bench for disp_sched
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_disp_sched;

  logic clk;
  logic reset;
  int   ecnt;
  int   tests;
  int   fails;

  disp_sched_if bus_if ();

  disp_sched #(
    .SCAN_DIV    (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since the last reset release: ticks land on multiples of 4,
  // frame ends on multiples of 32.
  always @(posedge clk) ecnt <= reset ? 0 : ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e);
    chk({tag, ".an"},  32'(bus_if.an),  32'(an_e));
    chk({tag, ".seg"}, 32'(bus_if.seg), 32'(seg_e));
  endtask

  task automatic goto(input int e);
    if (e <= ecnt) begin
      $display("FAIL goto: edge %0d already passed, now at %0d", e, ecnt);
      $fatal(1, "schedule overrun");
    end
    while (ecnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ev(input logic [7:0] a, input logic [15:0] d);
    bus_if.ev_addr  = a;
    bus_if.ev_data  = d;
    bus_if.ev_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ev_valid = 1'b0;
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    ecnt            = 0;
    reset           = 1'b0;
    bus_if.ev_valid = 1'b0;
    bus_if.ev_addr  = 8'h0;
    bus_if.ev_data  = 16'h0;
    bus_if.show     = 1'b0;
    bus_if.rdata    = 32'h0;
    bus_if.pclow    = 8'h3C;
    bus_if.state    = 5'd9;

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_disp("rst", 8'hFF, 7'h7F);
    chk("rst.busy", 32'(bus_if.busy), 32'd0);
    chk("rst.drop", 32'(bus_if.ev_drop), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Live status word 0000_3C09
    goto(3);
    chk_disp("pre_tick", 8'hFF, 7'h7F);
    goto(4);
    chk_disp("live.d0", 8'hFE, 7'h10);
    goto(8);
    chk_disp("live.d1", 8'hFD, 7'h40);
    goto(12);
    chk_disp("live.d2", 8'hFB, 7'h46);
    goto(16);
    chk_disp("live.d3", 8'hF7, 7'h30);
    chk("ev1.busy_pre", 32'(bus_if.busy), 32'd0);

    // Single event EE540007 held for two frame ends (E32, E64)
    pulse_ev(8'h54, 16'h0007);
    chk("ev1.busy", 32'(bus_if.busy), 32'd1);
    goto(20);
    chk_disp("ev1.d4", 8'hEF, 7'h19);
    goto(28);
    chk_disp("ev1.d6", 8'hBF, 7'h06);
    goto(36);
    chk_disp("ev1.d0", 8'hFE, 7'h78);
    goto(63);
    chk("ev1.busy_end", 32'(bus_if.busy), 32'd1);
    goto(64);
    chk("ev1.busy_drop", 32'(bus_if.busy), 32'd0);
    goto(68);
    chk_disp("ev1.live", 8'hFE, 7'h10);

    // X enters HOLD, A goes pending, B overwrites A
    pulse_ev(8'h33, 16'h3333);
    chk("ovr.busy", 32'(bus_if.busy), 32'd1);
    pulse_ev(8'h66, 16'h6666);
    chk("ovr.drop_a", 32'(bus_if.ev_drop), 32'd0);
    pulse_ev(8'h5A, 16'h1234);
    chk("ovr.drop_b", 32'(bus_if.ev_drop), 32'd1);
    goto(72);
    chk("ovr.drop_1cyc", 32'(bus_if.ev_drop), 32'd0);
    goto(100);
    chk_disp("ovr.x_d0", 8'hFE, 7'h30);
    goto(128);
    chk("ovr.busy_swap", 32'(bus_if.busy), 32'd1);
    chk("ovr.no_drop", 32'(bus_if.ev_drop), 32'd0);
    goto(132);
    chk_disp("ovr.b_d0", 8'hFE, 7'h19);
    goto(136);
    chk_disp("ovr.b_d1", 8'hFD, 7'h30);
    goto(191);
    chk("ovr.busy_end", 32'(bus_if.busy), 32'd1);
    goto(192);
    chk("ovr.live", 32'(bus_if.busy), 32'd0);

    // Y held; Z arrives exactly on Y's expiry edge (E256)
    pulse_ev(8'h77, 16'h7777);
    goto(228);
    chk_disp("exp.y_d0", 8'hFE, 7'h78);
    goto(255);
    chk("exp.busy_pre", 32'(bus_if.busy), 32'd1);
    pulse_ev(8'hC0, 16'h00C8);
    chk("exp.busy", 32'(bus_if.busy), 32'd1);
    chk("exp.drop", 32'(bus_if.ev_drop), 32'd0);
    goto(260);
    chk_disp("exp.z_d0", 8'hFE, 7'h00);
    goto(264);
    chk_disp("exp.z_d1", 8'hFD, 7'h46);
    goto(320);
    chk("exp.live", 32'(bus_if.busy), 32'd0);

    // Live rdata view 0000_00A5
    bus_if.show  = 1'b1;
    bus_if.rdata = 32'h0000_00A5;
    goto(324);
    chk_disp("rd.d0", 8'hFE, 7'h12);
    goto(328);
    chk_disp("rd.d1", 8'hFD, 7'h08);
    goto(332);
`ifdef DISP_BLANK_EN
    chk_disp("rd.d2", 8'hFF, 7'h7F);
`else
    chk_disp("rd.d2", 8'hFB, 7'h40);
`endif
    goto(352);
`ifdef DISP_BLANK_EN
    chk_disp("rd.d7", 8'hFF, 7'h7F);
`else
    chk_disp("rd.d7", 8'h7F, 7'h40);
`endif

    // Reset while holding with an event pending
    pulse_ev(8'h01, 16'h0001);
    pulse_ev(8'h02, 16'h0002);
    chk("mid.busy_pre", 32'(bus_if.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_disp("mid.rst", 8'hFF, 7'h7F);
    chk("mid.busy", 32'(bus_if.busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    goto(3);
    chk_disp("mid.blank", 8'hFF, 7'h7F);
    goto(4);
    chk_disp("mid.live_d0", 8'hFE, 7'h12);
    chk("mid.busy_post", 32'(bus_if.busy), 32'd0);
    goto(40);
    chk("mid.pend_gone", 32'(bus_if.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
